// File: rtl/smi_request_arbiter.sv
// Round-robin, frame-atomic arbiter funnelling NumPorts SMI request ports into one registered output.
// Optional macro SMI_ARB_PRIORITY_PORT0_EN gives port 0 strict priority whenever no frame is in progress.
module smi_request_arbiter #(
    parameter int DataIndexSize = 4,
    parameter int NumPorts      = 4,
    parameter int PortIdWidth   = 2,
    localparam int DataWidth    = (1 << DataIndexSize) * 8
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [NumPorts-1:0]           smiInReady,
    input  logic [8*NumPorts-1:0]         smiInEofc,
    input  logic [DataWidth*NumPorts-1:0] smiInData,
    output logic [NumPorts-1:0]           smiInStop,
    output logic                          smiOutReady,
    output logic [7:0]                    smiOutEofc,
    output logic [DataWidth-1:0]          smiOutData,
    output logic [PortIdWidth-1:0]        smiOutPortId,
    input  logic                          smiOutStop
);

`ifdef SMI_ARB_PRIORITY_PORT0_EN
    localparam bit Port0Priority = 1'b1;
`else
    localparam bit Port0Priority = 1'b0;
`endif

    typedef enum logic {ArbIdle, ArbLocked} arb_state_t;

    arb_state_t             state, state_next;
    logic [PortIdWidth-1:0] rr_ptr, rr_next;
    logic [PortIdWidth-1:0] grant_id, grant_next;
    logic [PortIdWidth-1:0] winner, sel;
    logic [PortIdWidth:0]   probe;
    logic                   any_ready, sel_valid, out_free, accept;
    logic [7:0]             sel_eofc;
    logic [DataWidth-1:0]   sel_data;

    function automatic logic [PortIdWidth-1:0] succ(input logic [PortIdWidth-1:0] id);
        if (id == PortIdWidth'(NumPorts - 1))
            return '0;
        return id + 1'b1;
    endfunction

    // Round-robin search starting at rr_ptr; the index wraps modulo NumPorts by subtraction.
    always_comb begin
        winner    = '0;
        any_ready = 1'b0;
        probe     = '0;
        for (int i = 0; i < NumPorts; i++) begin
            probe = {1'b0, rr_ptr} + (PortIdWidth+1)'(i);
            if (probe >= (PortIdWidth+1)'(NumPorts))
                probe = probe - (PortIdWidth+1)'(NumPorts);
            if (!any_ready && smiInReady[probe[PortIdWidth-1:0]]) begin
                winner    = probe[PortIdWidth-1:0];
                any_ready = 1'b1;
            end
        end
        if (Port0Priority && smiInReady[0]) begin
            winner    = '0;
            any_ready = 1'b1;
        end
    end

    assign out_free  = ~(smiOutReady & smiOutStop);
    assign sel       = (state == ArbLocked) ? grant_id : winner;
    assign sel_valid = (state == ArbLocked) ? smiInReady[grant_id] : any_ready;
    assign accept    = sel_valid & out_free;

    always_comb begin
        sel_eofc = '0;
        sel_data = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (sel == PortIdWidth'(p)) begin
                sel_eofc = smiInEofc[8*p +: 8];
                sel_data = smiInData[DataWidth*p +: DataWidth];
            end
        end
    end

    // A locked port keeps its Stop low even while its Ready is dropped mid-frame.
    always_comb begin
        smiInStop = '1;
        for (int p = 0; p < NumPorts; p++) begin
            if (out_free && (sel == PortIdWidth'(p)) && ((state == ArbLocked) || any_ready))
                smiInStop[p] = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        rr_next    = rr_ptr;
        grant_next = grant_id;
        case (state)
            ArbIdle: begin
                if (accept) begin
                    grant_next = winner;
                    if (sel_eofc != 8'h00) begin
                        if (!(Port0Priority && (winner == '0)))
                            rr_next = succ(winner);
                    end else begin
                        state_next = ArbLocked;
                    end
                end
            end
            ArbLocked: begin
                if (accept && (sel_eofc != 8'h00)) begin
                    state_next = ArbIdle;
                    if (!(Port0Priority && (grant_id == '0)))
                        rr_next = succ(grant_id);
                end
            end
            default: state_next = ArbIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= ArbIdle;
            rr_ptr      <= '0;
            grant_id    <= '0;
            smiOutReady <= 1'b0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_next;
            grant_id <= grant_next;
            if (out_free)
                smiOutReady <= accept;
        end
    end

    // Datapath half of the output stage carries no reset; it only matters when smiOutReady is set.
    always_ff @(posedge clk) begin
        if (out_free) begin
            smiOutEofc   <= sel_eofc;
            smiOutData   <= sel_data;
            smiOutPortId <= sel;
        end
    end

endmodule

// File: tb/tb_smi_request_arbiter.sv
// Randomized scoreboard bench for smi_request_arbiter against a frame-level arbitration model.
// Honours SMI_ARB_PRIORITY_PORT0_EN in the model when the macro is defined for the build.
module tb_smi_request_arbiter;
    localparam int DataIndexSize = 4;
    localparam int NumPorts      = 4;
    localparam int PortIdWidth   = 2;
    localparam int DataWidth     = 128;

    logic                          clk = 1'b0;
    logic                          srst = 1'b1;
    logic [NumPorts-1:0]           smiInReady = '0;
    logic [8*NumPorts-1:0]         smiInEofc = '0;
    logic [DataWidth*NumPorts-1:0] smiInData = '0;
    logic [NumPorts-1:0]           smiInStop;
    logic                          smiOutReady;
    logic [7:0]                    smiOutEofc;
    logic [DataWidth-1:0]          smiOutData;
    logic [PortIdWidth-1:0]        smiOutPortId;
    logic                          smiOutStop = 1'b0;

    smi_request_arbiter #(
        .DataIndexSize(DataIndexSize),
        .NumPorts(NumPorts),
        .PortIdWidth(PortIdWidth)
    ) dut (
        .clk(clk),
        .srst(srst),
        .smiInReady(smiInReady),
        .smiInEofc(smiInEofc),
        .smiInData(smiInData),
        .smiInStop(smiInStop),
        .smiOutReady(smiOutReady),
        .smiOutEofc(smiOutEofc),
        .smiOutData(smiOutData),
        .smiOutPortId(smiOutPortId),
        .smiOutStop(smiOutStop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]           port;
        logic [7:0]           eofc;
        logic [DataWidth-1:0] data;
    } flit_t;

    flit_t expq[$];
    int    n_cmp = 0;
    int    n_err = 0;

    // Upstream driver state: each port works through randomly sized frames.
    logic [DataWidth-1:0] cur_data [NumPorts];
    logic [7:0]           cur_eofc [NumPorts];
    int                   remain   [NumPorts];
    bit                   midframe [NumPorts];
    bit                   rdy      [NumPorts];
    bit                   drain = 1'b0;

    // Arbitration model: current frame owner (-1 when none), round-robin start, output occupancy.
    int owner     = -1;
    int rr        = 0;
    bit out_valid = 1'b0;

    task automatic checkOutput(input string name, input logic [DataWidth-1:0] act,
                               input logic [DataWidth-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit prio0(input int p);
`ifdef SMI_ARB_PRIORITY_PORT0_EN
        return p == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic newFlit(input int p);
        cur_data[p] = {$urandom(), $urandom(), $urandom(), $urandom()};
        cur_eofc[p] = (remain[p] == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
    endtask

    task automatic newFrame(input int p);
        remain[p]   = $urandom_range(1, 4);
        midframe[p] = 1'b0;
        newFlit(p);
    endtask

    task automatic applyStimulus(input int p_ready, input int p_stop, input bit rst);
        bit out_free;
        bit accept;
        int sel;
        @(negedge clk);
        srst = rst;
        for (int p = 0; p < NumPorts; p++) begin
            rdy[p] = drain ? midframe[p] : ($urandom_range(0, 99) < p_ready);
            smiInReady[p] = rdy[p];
            smiInEofc[8*p +: 8] = cur_eofc[p];
            smiInData[DataWidth*p +: DataWidth] = cur_data[p];
        end
        smiOutStop = ($urandom_range(0, 99) < p_stop);

        out_free = !(out_valid && smiOutStop);
        sel = -1;
        if (owner >= 0) begin
            sel = owner;
        end else begin
`ifdef SMI_ARB_PRIORITY_PORT0_EN
            if (rdy[0]) sel = 0;
`endif
            for (int k = 0; k < NumPorts; k++) begin
                if (sel < 0 && rdy[(rr + k) % NumPorts]) sel = (rr + k) % NumPorts;
            end
        end
        accept = (sel >= 0) && rdy[sel] && out_free;

        #1;
        if (!rst) begin
            checkOutput("out_ready", smiOutReady, out_valid);
            for (int p = 0; p < NumPorts; p++) begin
                if (rdy[p])
                    checkOutput($sformatf("in_stop[%0d]", p), smiInStop[p], !(out_free && p == sel));
            end
        end

        @(posedge clk);
        if (rst) begin
            owner = -1;
            rr = 0;
            out_valid = 1'b0;
            expq.delete();
            for (int p = 0; p < NumPorts; p++) newFrame(p);
        end else begin
            if (accept) begin
                expq.push_back('{port: 8'(sel), eofc: cur_eofc[sel], data: cur_data[sel]});
                if (cur_eofc[sel] != 8'h00) begin
                    owner = -1;
                    if (!prio0(sel)) rr = (sel + 1) % NumPorts;
                end else begin
                    owner = sel;
                end
                remain[sel]--;
                if (remain[sel] == 0) begin
                    newFrame(sel);
                end else begin
                    midframe[sel] = 1'b1;
                    newFlit(sel);
                end
            end
            if (out_free) out_valid = accept;
        end
    endtask

    // Monitor: pops the scoreboard on each downstream transfer and checks stalled flits stay put.
    initial begin
        flit_t                e;
        bit                   hold = 1'b0;
        logic [DataWidth-1:0] hold_data;
        logic [7:0]           hold_eofc;
        logic [PortIdWidth-1:0] hold_port;
        forever begin
            @(negedge clk);
            #2;
            if (srst) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                checkOutput("hold_ready", smiOutReady, 1);
                checkOutput("hold_data", smiOutData, hold_data);
                checkOutput("hold_eofc", smiOutEofc, hold_eofc);
                checkOutput("hold_port", smiOutPortId, hold_port);
            end
            if (smiOutReady === 1'b1 && smiOutStop == 1'b0) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("[TB] FAIL spurious_flit: got port %0d data %0h expected none at %0t",
                             smiOutPortId, smiOutData, $time);
                end else begin
                    e = expq.pop_front();
                    checkOutput("out_data", smiOutData, e.data);
                    checkOutput("out_eofc", smiOutEofc, e.eofc);
                    checkOutput("out_port", smiOutPortId, e.port);
                end
            end
            hold = (smiOutReady === 1'b1) && smiOutStop;
            hold_data = smiOutData;
            hold_eofc = smiOutEofc;
            hold_port = smiOutPortId;
        end
    end

    initial begin
        for (int p = 0; p < NumPorts; p++) newFrame(p);
        $display("[TB] starting smi_request_arbiter bench");
        repeat (3) applyStimulus(0, 0, 1'b1);
        repeat (40) applyStimulus(100, 0, 1'b0);
        repeat (500) applyStimulus(60, 30, 1'b0);
        repeat (30) applyStimulus(90, 80, 1'b0);
        repeat (20) applyStimulus(100, 10, 1'b0);
        applyStimulus(70, 20, 1'b1);
        repeat (400) applyStimulus(50, 25, 1'b0);
        drain = 1'b1;
        repeat (60) applyStimulus(0, 0, 1'b0);
        @(negedge clk);
        #3;
        checkOutput("drain_queue_empty", expq.size(), 0);
        checkOutput("drain_out_ready", smiOutReady, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/smi_request_arbiter.md
Name: smi_request_arbiter

Overview:
- Round-robin, frame-atomic arbiter that shares one downstream SMI request port between NumPorts upstream SMI requesters.
- Sits in front of the SMI-to-AXI read and write adaptors.
- Emits the winning port index alongside every flit so the response path can steer replies back to the requester.
- Output is a single registered stage using SMI Ready/Eofc/Data/Stop flow control.

Parameters:
- DataIndexSize, 4, log2 of bytes per flit; DataWidth = (1 << DataIndexSize)*8.
- NumPorts, 4, number of upstream requesters; legal range 2..8.
- PortIdWidth, 2, width of port index; must hold NumPorts-1.

Ports:
- clk  in  1  system clock
- srst  in  1  synchronous active-high reset
- smiInReady  in  NumPorts  per-port flit valid
- smiInEofc  in  8*NumPorts  per-port end-of-frame control; port i at [8i+7:8i]
- smiInData  in  DataWidth*NumPorts  per-port flit data; port i at [DataWidth*i +: DataWidth]
- smiInStop  out  NumPorts  per-port backpressure
- smiOutReady  out  1  downstream flit valid
- smiOutEofc  out  8  downstream end-of-frame control
- smiOutData  out  DataWidth  downstream flit data
- smiOutPortId  out  PortIdWidth  source port of the current output flit
- smiOutStop  in  1  downstream backpressure

Behaviour:
- Transfer rules:
  - A flit transfers on any interface in a cycle where Ready=1 and Stop=0.
  - Eofc != 0 marks the last flit of a frame.
- Output register:
  - Loads when ~(smiOutReady & smiOutStop).
  - Otherwise holds Ready, Eofc, Data and PortId.
  - Reset: smiOutReady=0. smiOutEofc, smiOutData and smiOutPortId are non-reset datapath registers.
- Accept condition: outFree = ~(smiOutReady & smiOutStop).
- smiInStop[i] = 1 unless port i is the selected port and outFree=1. A combinational Ready->Stop path is permitted; upstream must not combinationally feed Stop back to Ready.
- State machine, two states: ArbIdle and ArbLocked.
  - ArbIdle, selection:
    - Winner is the first port with smiInReady set, searching from rrPtr upward and wrapping modulo NumPorts.
    - If any port is ready and outFree=1, the winner's flit is accepted this cycle and grantId <= winner.
    - Accepted flit with Eofc=0: go to ArbLocked.
    - Accepted flit with Eofc!=0 (single-flit frame): stay in ArbIdle and set rrPtr <= winner+1, wrapping.
    - No acceptance (nothing ready, or outFree=0): no state change and no grant is latched. The winner may change in a later cycle.
  - ArbLocked:
    - Only port grantId is eligible. Its flits are accepted whenever outFree=1.
    - Accepted flit with Eofc!=0: go to ArbIdle and set rrPtr <= grantId+1, wrapping.
    - Other ports stay stopped, even if the granted port deasserts Ready mid-frame.
- Throughput: back-to-back frames from different ports need no idle cycle; the next frame's first flit may be accepted the cycle after the previous last flit.
- Latency: one cycle from input acceptance to smiOutReady.
- Reset: state=ArbIdle, rrPtr=0, grantId=0, smiOutReady=0, all smiInStop follow the combinational rule. Assertion mid-frame abandons the frame with no flush; an upstream that is mid-frame must also be reset.
- Wrap: rrPtr = NumPorts-1 advances to 0.
- All pointer arithmetic is modulo NumPorts, so non-power-of-two NumPorts is legal.

Optional Feature:
- Macro: SMI_ARB_PRIORITY_PORT0_EN.
- Defined: port 0 has strict priority in ArbIdle. If smiInReady[0]=1 it wins regardless of rrPtr. Round-robin among ports 1..NumPorts-1 continues, and rrPtr is not advanced by port-0 grants. Frames in progress are never pre-empted.
- Undefined: pure round-robin as above.

Test Plan:
- Reset, then port 2 sends a 3-flit frame (Eofc 0,0,16) with no Stop -> smiOutPortId=2 for 3 consecutive cycles starting 1 cycle after the first accept; smiInStop[2]=0 throughout; rrPtr ends at 3.
- All 4 ports continuously offer single-flit frames -> grant order 0,1,2,3,0,1 with no bubbles on smiOutReady.
- Port 1 mid-frame with smiInReady[1] dropped for 2 cycles while port 3 is ready -> port 3 stays stopped; no port-3 flit appears until port 1's Eofc!=0 flit is output.
- smiOutStop held high for 4 cycles with an output flit pending -> smiOutData/Eofc/PortId stable; granted port's smiInStop=1; resumes with no loss or duplication.
- Reset asserted in ArbLocked on flit 2 of 4 -> next cycle smiOutReady=0; next grant follows rrPtr=0 ordering.
- With SMI_ARB_PRIORITY_PORT0_EN, ports 0 and 2 both ready and rrPtr=2 -> port 0 granted first; without the macro, port 2 granted first.
